// File: rtl/data_mem_param.sv
// -----------------------------------------------------------------------------
// data_mem_param
// Byte-addressed data memory for the CPU MEM stage. Supports byte/half/word
// (and double-word when DATA_W = 64) loads and stores. Loads can be sign- or
// zero-extended. A single valid/ready request port feeds a response strobe
// that arrives RD_LAT cycles after accept.
//
// Ports
//   CLK         clock, all logic on the rising edge
//   RST         synchronous active-high reset (memory contents are kept)
//   req_valid   request present
//   req_ready   block can accept a request (low while RST = 1)
//   req_we      1 = store, 0 = load
//   req_size    access is (1 << req_size) bytes
//   req_signed  loads: 1 = sign-extend, 0 = zero-extend
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   rsp_valid   one-cycle response strobe
//   rsp_rdata   extended load result (0 for stores and errors)
//   rsp_err     request rejected (size, alignment or range)
// -----------------------------------------------------------------------------
module data_mem_param #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 256,
    parameter int RD_LAT    = 1,
    parameter int INIT_BASE = 6,
    parameter int INIT_MAX  = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int NB     = DATA_W / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int AW     = $clog2(DEPTH);
    localparam int HI_LSB = OFF_W + AW;

    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;
    typedef enum logic {IDLE, BUSY} state_t;

    // Power-up image: mem[i] = min(INIT_BASE + i, INIT_MAX).
    function automatic mem_t init_mem();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            if (INIT_BASE + i > INIT_MAX) m[i] = DATA_W'(INIT_MAX);
            else                          m[i] = DATA_W'(INIT_BASE + i);
        end
        return m;
    endfunction

    // Contents come from the declaration initialiser; reset never touches them.
    mem_t mem_q = init_mem();

    state_t              state_q;
    logic [2:0]          cnt_q;
    logic                ready_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic [DATA_W-1:0]   pend_rdata_q;
    logic                pend_err_q;

    logic                accept;
    logic [OFF_W-1:0]    offset;
    logic [AW-1:0]       index;
    logic [6:0]          acc_bits;
    logic [3:0]          size_mask;
    logic                req_err;
    logic [DATA_W-1:0]   rd_shift;
    logic [DATA_W-1:0]   rd_tmp;
    logic signed [DATA_W-1:0] rd_tmp_s;
    logic [6:0]          ext_sh;
    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   wdata_shift;
    logic [NB-1:0]       lane_sel;

    assign req_ready = ready_q && !RST;
    assign accept    = req_valid && req_ready;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        offset    = req_addr[OFF_W-1:0];
        index     = req_addr[OFF_W +: AW];
        acc_bits  = 7'd8 << req_size;
        size_mask = 4'((4'd1 << req_size) - 4'd1);
        req_err   = (acc_bits > 7'(DATA_W))
                 || ((4'(offset) & size_mask) != 4'd0)
                 || ((req_addr >> HI_LSB) != 32'd0);

        // Move the addressed lanes to the LSBs, then push them to the top and
        // shift back down so the extension comes out of the shift itself.
        rd_shift  = mem_q[index] >> {offset, 3'b000};
        ext_sh    = 7'(DATA_W) - acc_bits;
        rd_tmp    = rd_shift << ext_sh;
        rd_tmp_s  = rd_tmp;
        if (req_we || req_err) load_data = '0;
        else if (req_signed)   load_data = rd_tmp_s >>> ext_sh;
        else                   load_data = rd_tmp >> ext_sh;

        wdata_shift = req_wdata << {offset, 3'b000};
    end

    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
        assign lane_sel[gi] = (gi >= int'(offset))
                           && (gi < int'(offset) + (1 << req_size));
    end

    // Byte-lane store at the accept edge; rejected requests never write.
    always_ff @(posedge CLK) begin
        if (accept && req_we && !req_err) begin
            for (int l = 0; l < NB; l++) begin
                if (lane_sel[l]) mem_q[index][l*8 +: 8] <= wdata_shift[l*8 +: 8];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
            pend_rdata_q <= '0;
            pend_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            if (RD_LAT == 1) begin
                // Single-cycle latency: never leaves IDLE, fully pipelined.
                ready_q <= 1'b1;
                if (accept) begin
                    rsp_valid_q <= 1'b1;
                    rsp_rdata_q <= load_data;
                    rsp_err_q   <= req_err;
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        ready_q <= 1'b1;
                        if (accept) begin
                            state_q      <= BUSY;
                            cnt_q        <= 3'(RD_LAT - 1);
                            ready_q      <= 1'b0;
                            pend_rdata_q <= load_data;
                            pend_err_q   <= req_err;
                        end
                    end
                    BUSY: begin
                        cnt_q <= cnt_q - 3'd1;
                        // Final BUSY edge: deliver the response and reopen the
                        // port so the next accept lands on the edge ending it.
                        if (cnt_q == 3'd1) begin
                            state_q     <= IDLE;
                            ready_q     <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            rsp_rdata_q <= pend_rdata_q;
                            rsp_err_q   <= pend_err_q;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_param.sv
module tb_data_mem_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;

    // RD_LAT = 1 instance
    logic        v1 = 1'b0, we1 = 1'b0, sg1 = 1'b0;
    logic [1:0]  sz1 = 2'd0;
    logic [31:0] a1 = '0, wd1 = '0;
    logic        rdy1, rv1, er1;
    logic [31:0] rd1;

    // RD_LAT = 3 instance
    logic        v3 = 1'b0, we3 = 1'b0, sg3 = 1'b0;
    logic [1:0]  sz3 = 2'd0;
    logic [31:0] a3 = '0, wd3 = '0;
    logic        rdy3, rv3, er3;
    logic [31:0] rd3;

    always #5 clk = ~clk;

    data_mem_param #(.DATA_W(32), .DEPTH(256), .RD_LAT(1), .INIT_BASE(6), .INIT_MAX(255)) dut1 (
        .CLK(clk), .RST(rst), .req_valid(v1), .req_ready(rdy1), .req_we(we1),
        .req_size(sz1), .req_signed(sg1), .req_addr(a1), .req_wdata(wd1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1));

    data_mem_param #(.DATA_W(32), .DEPTH(256), .RD_LAT(3), .INIT_BASE(6), .INIT_MAX(255)) dut3 (
        .CLK(clk), .RST(rst), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
        .req_size(sz3), .req_signed(sg3), .req_addr(a3), .req_wdata(wd3),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3));

    // One complete transaction on the RD_LAT = 1 instance.
    task automatic req1(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        v1 = 1'b1; we1 = we; sz1 = sz; sg1 = sg; a1 = a; wd1 = wd;
        n = 0;
        while (rdy1 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        v1 = 1'b0;
        n = 0;
        while (rv1 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (rv1 !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req1_timeout addr=%h got rsp_valid=%b want 1", a, rv1);
        end
        rd = rd1; er = er1;
        $display("txn dut1 we=%0d size=%0d signed=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
                 we, sz, sg, a, wd, rd, er);
    endtask

    // One complete transaction on the RD_LAT = 3 instance.
    task automatic req3(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
        int n;
        @(negedge clk);
        v3 = 1'b1; we3 = we; sz3 = sz; sg3 = sg; a3 = a; wd3 = wd;
        n = 0;
        while (rdy3 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        v3 = 1'b0;
        n = 0;
        while (rv3 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        if (rv3 !== 1'b1) begin
            checks++; errors++;
            $display("FAIL req3_timeout addr=%h got rsp_valid=%b want 1", a, rv3);
        end
        rd = rd3; er = er3;
        $display("txn dut3 we=%0d size=%0d signed=%0d addr=%h wdata=%h -> rdata=%h err=%0d",
                 we, sz, sg, a, wd, rd, er);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL rst_ready1 got %b want 0", rdy1); end
        checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL rst_valid1 got %b want 0", rv1); end
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rst_rdata1 got %h want 0", rd1); end
        checks++; if (er1 !== 1'b0) begin errors++; $display("FAIL rst_err1 got %b want 0", er1); end
        checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL rst_ready3 got %b want 0", rdy3); end
        checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL rst_valid3 got %b want 0", rv3); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL rel_ready1 got %b want 1", rdy1); end
        checks++; if (rdy3 !== 1'b1) begin errors++; $display("FAIL rel_ready3 got %b want 1", rdy3); end
        $display("txn reset released");
    endtask

    task automatic test_powerup();
        logic [31:0] rd; logic er;
        req1(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
        checks++; if (rd !== 32'd6 || er !== 1'b0) begin errors++; $display("FAIL pu_w0 got %h/%b want 00000006/0", rd, er); end
        req1(1'b0, 2'd2, 1'b0, 32'h4, 32'h0, rd, er);
        checks++; if (rd !== 32'd7 || er !== 1'b0) begin errors++; $display("FAIL pu_w1 got %h/%b want 00000007/0", rd, er); end
        req1(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, rd, er);
        checks++; if (rd !== 32'd255 || er !== 1'b0) begin errors++; $display("FAIL pu_w255 got %h/%b want 000000ff/0", rd, er); end
    endtask

    task automatic test_subword();
        logic [31:0] rd; logic er;
        req1(1'b1, 2'd2, 1'b0, 32'h10, 32'hF08180FF, rd, er);
        checks++; if (rd !== 32'h0 || er !== 1'b0) begin errors++; $display("FAIL sw_store got %h/%b want 00000000/0", rd, er); end
        req1(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, rd, er);
        checks++; if (rd !== 32'hFFFFFFFF) begin errors++; $display("FAIL lb_10 got %h want ffffffff", rd); end
        req1(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, rd, er);
        checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_11 got %h want 00000080", rd); end
        req1(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, rd, er);
        checks++; if (rd !== 32'hFFFFF081) begin errors++; $display("FAIL lh_12 got %h want fffff081", rd); end
        req1(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, rd, er);
        checks++; if (rd !== 32'h0000F081) begin errors++; $display("FAIL lhu_12 got %h want 0000f081", rd); end
        req1(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, rd, er);
        checks++; if (rd !== 32'hFFFFFFF0) begin errors++; $display("FAIL lb_13 got %h want fffffff0", rd); end
        req1(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, rd, er);
        checks++; if (rd !== 32'hFFFF80FF) begin errors++; $display("FAIL lh_10 got %h want ffff80ff", rd); end
    endtask

    task automatic test_merge();
        logic [31:0] rd; logic er;
        req1(1'b1, 2'd1, 1'b0, 32'h22, 32'h0000BEEF, rd, er);
        req1(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
        checks++; if (rd !== 32'hBEEF000E) begin errors++; $display("FAIL merge_half got %h want beef000e", rd); end
        req1(1'b1, 2'd0, 1'b0, 32'h21, 32'h1234565A, rd, er);
        req1(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
        checks++; if (rd !== 32'hBEEF5A0E) begin errors++; $display("FAIL merge_byte got %h want beef5a0e", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er;
        req1(1'b1, 2'd1, 1'b0, 32'h21, 32'h00001111, rd, er);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_half21 got %h/%b want 00000000/1", rd, er); end
        req1(1'b1, 2'd2, 1'b0, 32'h22, 32'h22222222, rd, er);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_word22 got %h/%b want 00000000/1", rd, er); end
        req1(1'b1, 2'd3, 1'b0, 32'h20, 32'h33333333, rd, er);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_size3 got %h/%b want 00000000/1", rd, er); end
        req1(1'b1, 2'd2, 1'b0, 32'h400, 32'h44444444, rd, er);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_range got %h/%b want 00000000/1", rd, er); end
        req1(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, rd, er);
        checks++; if (rd !== 32'hBEEF5A0E || er !== 1'b0) begin errors++; $display("FAIL err_readback20 got %h/%b want beef5a0e/0", rd, er); end
        req1(1'b0, 2'd1, 1'b1, 32'h21, 32'h0, rd, er);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL err_load21 got %h/%b want 00000000/1", rd, er); end
        req1(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, rd, er);
        checks++; if (rd !== 32'd6 || er !== 1'b0) begin errors++; $display("FAIL err_readback0 got %h/%b want 00000006/0", rd, er); end
    endtask

    task automatic test_lat3_timing();
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b0; sz3 = 2'd2; sg3 = 1'b0; a3 = 32'h4; wd3 = 32'h0;
        @(negedge clk); // after E0
        checks++; if (rdy3 !== 1'b0 || rv3 !== 1'b0) begin errors++; $display("FAIL l3_e0 got ready=%b valid=%b want 0/0", rdy3, rv3); end
        a3 = 32'h8;     // second request, held valid
        @(negedge clk); // after E1
        checks++; if (rdy3 !== 1'b0 || rv3 !== 1'b0) begin errors++; $display("FAIL l3_e1 got ready=%b valid=%b want 0/0", rdy3, rv3); end
        @(negedge clk); // after E2
        checks++; if (rdy3 !== 1'b1 || rv3 !== 1'b1) begin errors++; $display("FAIL l3_e2 got ready=%b valid=%b want 1/1", rdy3, rv3); end
        checks++; if (rd3 !== 32'd7 || er3 !== 1'b0) begin errors++; $display("FAIL l3_data1 got %h/%b want 00000007/0", rd3, er3); end
        @(negedge clk); // after E3: second request accepted
        checks++; if (rv3 !== 1'b0 || rdy3 !== 1'b0) begin errors++; $display("FAIL l3_e3 got valid=%b ready=%b want 0/0", rv3, rdy3); end
        checks++; if (rd3 !== 32'd7) begin errors++; $display("FAIL l3_hold got %h want 00000007", rd3); end
        v3 = 1'b0;
        @(negedge clk); // after E4
        checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL l3_e4 got valid=%b want 0", rv3); end
        @(negedge clk); // after E5
        checks++; if (rv3 !== 1'b1 || rd3 !== 32'd8) begin errors++; $display("FAIL l3_data2 got %b/%h want 1/00000008", rv3, rd3); end
        $display("txn dut3 latency sequence loads 0x4, 0x8");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b1; sz3 = 2'd2; sg3 = 1'b0; a3 = 32'h30; wd3 = 32'hCAFEF00D;
        @(negedge clk); // after E0: store accepted, switch to load
        we3 = 1'b0; wd3 = 32'h0;
        @(negedge clk); // after E1
        @(negedge clk); // after E2: store response
        checks++; if (rv3 !== 1'b1 || rd3 !== 32'h0 || er3 !== 1'b0) begin errors++; $display("FAIL b2b_store got %b/%h/%b want 1/00000000/0", rv3, rd3, er3); end
        @(negedge clk); // after E3: load accepted
        checks++; if (rdy3 !== 1'b0) begin errors++; $display("FAIL b2b_accept got ready=%b want 0", rdy3); end
        v3 = 1'b0;
        @(negedge clk); // after E4
        @(negedge clk); // after E5
        checks++; if (rv3 !== 1'b1 || rd3 !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_load got %b/%h want 1/cafef00d", rv3, rd3); end
        @(negedge clk); // after E6
        checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL b2b_one_cycle got valid=%b want 0", rv3); end
        $display("txn dut3 back-to-back store/load 0x30");
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er;
        @(negedge clk);
        v3 = 1'b1; we3 = 1'b1; sz3 = 2'd2; sg3 = 1'b0; a3 = 32'h40; wd3 = 32'h13572468;
        @(negedge clk); // after E0
        v3 = 1'b0; rst = 1'b1;
        @(negedge clk); // after E1 (in reset)
        checks++; if (rv3 !== 1'b0 || rd3 !== 32'h0 || er3 !== 1'b0 || rdy3 !== 1'b0) begin
            errors++; $display("FAIL rm_reset got v=%b d=%h e=%b r=%b want 0/00000000/0/0", rv3, rd3, er3, rdy3); end
        @(negedge clk); // after E2: response would have been here
        checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL rm_dropped got valid=%b want 0", rv3); end
        rst = 1'b0;
        @(negedge clk); // after release edge
        checks++; if (rdy3 !== 1'b1 || rv3 !== 1'b0) begin errors++; $display("FAIL rm_release got ready=%b valid=%b want 1/0", rdy3, rv3); end
        @(negedge clk);
        checks++; if (rv3 !== 1'b0) begin errors++; $display("FAIL rm_quiet got valid=%b want 0", rv3); end
        req3(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, rd, er);
        checks++; if (rd !== 32'h13572468 || er !== 1'b0) begin errors++; $display("FAIL rm_readback got %h/%b want 13572468/0", rd, er); end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_subword();
        test_merge();
        test_errors();
        test_lat3_timing();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
